// File: rtl/msi_cache_ctrl_n.sv
// ============================================================================
// Module : msi_cache_ctrl_n
// Brief  : Direct-mapped MSI cache controller with snooping and bus arbitration
// Rev    : 1.0
// ============================================================================
`default_nettype none

module msi_cache_ctrl_n #(
  parameter int ADDR_W  = 8,
  parameter int INDEX_W = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  output logic              ready,
  output logic              done,
  output logic              hit,
  output logic [1:0]        stat_out,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [1:0]        bus_cmd,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_cs,
  input  logic              mem_ready,
  input  logic              snoop_valid,
  input  logic [1:0]        snoop_cmd,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_flush,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 2 ** INDEX_W;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b10;
  localparam logic [1:0] ST_M = 2'b11;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_RD   = 2'b01;
  localparam logic [1:0] CMD_RDX  = 2'b10;
  localparam logic [1:0] CMD_UPGR = 2'b11;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_WB_ARB = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_ARB    = 3'd4;
  localparam logic [2:0] S_MEM    = 3'd5;
  localparam logic [2:0] S_FILL   = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [TAG_W-1:0]  tag_q [LINES];
  logic [TAG_W-1:0]  tag_d [LINES];
  logic [1:0]        lst_q [LINES];
  logic [1:0]        lst_d [LINES];
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [1:0]        cmd_q, cmd_d;
  logic              hit_q, hit_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic              flush_q, flush_d;

  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [1:0]         w_line_st;
  logic [TAG_W-1:0]   w_line_tag;
  logic               w_hit;
  logic               w_done_hit;
  logic [1:0]         w_miss_cmd;
  logic [1:0]         w_arb_cmd;
  logic [INDEX_W-1:0] w_s_idx;
  logic [TAG_W-1:0]   w_s_tag;
  logic [1:0]         w_s_st;
  logic               w_s_match;

  assign w_idx      = addr_q[INDEX_W-1:0];
  assign w_tag      = addr_q[ADDR_W-1:INDEX_W];
  assign w_line_st  = lst_q[w_idx];
  assign w_line_tag = tag_q[w_idx];
  assign w_hit      = (w_line_tag == w_tag) && (w_line_st != ST_I);
  assign w_done_hit = w_hit && (!write_q || (w_line_st == ST_M));
  assign w_miss_cmd = write_q ? CMD_RDX : CMD_RD;
  // An upgrade is only legal while we still hold the line; otherwise fetch it.
  assign w_arb_cmd  = ((cmd_q == CMD_UPGR) && !w_hit) ? CMD_RDX : cmd_q;

  assign w_s_idx   = snoop_addr[INDEX_W-1:0];
  assign w_s_tag   = snoop_addr[ADDR_W-1:INDEX_W];
  assign w_s_st    = lst_q[w_s_idx];
  assign w_s_match = snoop_valid && (tag_q[w_s_idx] == w_s_tag) && (w_s_st != ST_I);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      cmd_q      <= CMD_NONE;
      hit_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      flush_q    <= 1'b0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i] <= '0;
        lst_q[i] <= ST_I;
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      cmd_q      <= cmd_d;
      hit_q      <= hit_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      flush_q    <= flush_d;
      tag_q      <= tag_d;
      lst_q      <= lst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (w_done_hit)              state_d = S_DONE;
        else if (w_hit)              state_d = S_ARB;
        else if (w_line_st == ST_M)  state_d = S_WB_ARB;
        else                         state_d = S_ARB;
      end
      // A snoop may demote the victim while we wait; then nothing to write back.
      S_WB_ARB: begin
        if (w_line_st != ST_M) state_d = S_ARB;
        else if (bus_gnt)      state_d = S_WB;
      end
      S_WB:     if (mem_ready) state_d = S_ARB;
      S_ARB:    if (bus_gnt) state_d = (w_arb_cmd == CMD_UPGR) ? S_FILL : S_MEM;
      S_MEM:    if (mem_ready) state_d = S_FILL;
      S_FILL:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    write_d    = write_q;
    cmd_d      = cmd_q;
    hit_d      = hit_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    flush_d    = 1'b0;
    tag_d      = tag_q;
    lst_d      = lst_q;

    if (w_s_match) begin
      case (snoop_cmd)
        CMD_RD: if (w_s_st == ST_M) begin
          lst_d[w_s_idx] = ST_S;
          flush_d        = 1'b1;
        end
        CMD_RDX: begin
          lst_d[w_s_idx] = ST_I;
          flush_d        = (w_s_st == ST_M);
        end
        CMD_UPGR: if (w_s_st == ST_S) lst_d[w_s_idx] = ST_I;
        default: ;
      endcase
    end

    // Own-transaction updates come after the snoop so they take priority.
    case (state_q)
      S_IDLE: if (req) begin
        addr_d  = paddr;
        write_d = pwrite;
      end
      S_LOOKUP: begin
        hit_d = w_done_hit;
        cmd_d = w_hit ? CMD_UPGR : w_miss_cmd;
        if (w_done_hit) begin
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
        end else begin
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
        end
      end
      S_WB:   if (mem_ready) lst_d[w_idx] = ST_I;
      S_ARB:  cmd_d = w_arb_cmd;
      S_FILL: begin
        tag_d[w_idx] = w_tag;
        lst_d[w_idx] = write_q ? ST_M : ST_S;
      end
      default: ;
    endcase
  end

  always_comb begin
    ready    = (state_q == S_IDLE);
    done     = (state_q == S_DONE);
    hit      = (state_q == S_DONE) && hit_q;
    stat_out = (state_q == S_DONE) ? w_line_st : ST_I;
    bus_req  = (state_q == S_WB_ARB) || (state_q == S_WB) ||
               (state_q == S_ARB)    || (state_q == S_MEM);
    bus_cmd  = CMD_NONE;
    bus_addr = '0;
    if (state_q == S_ARB) begin
      bus_cmd  = w_arb_cmd;
      bus_addr = addr_q;
    end else if (state_q == S_MEM) begin
      bus_cmd  = cmd_q;
      bus_addr = addr_q;
    end
    wb_addr  = (state_q == S_WB) ? {w_line_tag, w_idx} : '0;
    mem_wr   = (state_q == S_WB);
    mem_rd   = (state_q == S_MEM);
    mem_cs   = (state_q == S_WB) || (state_q == S_MEM);
  end

  assign snoop_flush = flush_q;
  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;

endmodule

`default_nettype wire
